uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: word handshake into the UART transmitter.
// The producer drives word and request; the transmitter returns ready.
interface uart_tx_if;
  logic [7:0] d_in_tx;
  logic       tx_start;
  logic       tx_ready;

  modport master (
    output d_in_tx,
    output tx_start,
    input  tx_ready
  );

  modport slave (
    input  d_in_tx,
    input  tx_start,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8E1 serialiser with one-word holding buffer.
// Bit timing is taken from the shared baud enable bclk_tx.
module uart_tx #(
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     bclk_tx,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t     state;
  logic [7:0] hold_q;
  logic       hold_valid;
  logic [7:0] shift_q;
  logic [2:0] cnt_q;
  logic       stop_q;
  logic       par_q;

  logic accept;
  logic xfer;
  logic stop_last;

  assign bus.tx_ready = !hold_valid;
  assign accept       = bus.tx_start && !hold_valid;
  assign stop_last    = (stop_q == STOP_LAST);

  // buffer moves to the shift register at a frame boundary tick
  assign xfer = bclk_tx && hold_valid &&
                ((state == IDLE) ||
                 (state == STOP && stop_last));

  // holding buffer: accept when empty, release on transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_q     <= bus.d_in_tx;
      hold_valid <= 1'b1;
    end else if (xfer) begin
      hold_valid <= 1'b0;
    end
  end

  // frame sequencer; every output is registered and moves on ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (bclk_tx) begin
        unique case (state)
          IDLE: begin
            if (hold_valid) begin
              shift_q <= hold_q;
              par_q   <= ^hold_q;
              tx      <= 1'b0;
              tx_busy <= 1'b1;
              state   <= START;
            end
          end
          START: begin
            tx      <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            cnt_q   <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (cnt_q != 3'd7) begin
              tx      <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              cnt_q   <= cnt_q + 3'd1;
            end else if (PARITY_EN != 0) begin
              tx    <= par_q;
              state <= PARITY;
            end else begin
              tx     <= 1'b1;
              stop_q <= 1'b0;
              state  <= STOP;
            end
          end
          PARITY: begin
            tx     <= 1'b1;
            stop_q <= 1'b0;
            state  <= STOP;
          end
          STOP: begin
            if (!stop_last) begin
              stop_q <= stop_q + 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (hold_valid) begin
                shift_q <= hold_q;
                par_q   <= ^hold_q;
                tx      <= 1'b0;
                state   <= START;
              end else begin
                tx_busy <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          default: begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames for two uart_tx variants.
// Line periods are compared with frames built from the framing rules.
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bclk_tx;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  uart_tx_if if_a ();
  uart_tx_if if_b ();

  int vectors = 0;
  int miscompares = 0;
  int div = 4;
  int phase = 0;
  bit mon_sel = 1'b0;

  logic obs[$];
  logic expq[$];
  int   exp_done[$];
  int   done_idx[$];
  logic done_busy[$];
  int   done_cnt = 0;
  int   hold_err = 0;
  logic last_tx = 1'b1;

  uart_tx #(.PARITY_EN(1), .STOP_BITS(1)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .bclk_tx (bclk_tx),
    .bus     (if_a),
    .tx      (tx_a),
    .tx_busy (busy_a),
    .tx_done (done_a)
  );

  uart_tx #(.PARITY_EN(0), .STOP_BITS(2)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .bclk_tx (bclk_tx),
    .bus     (if_b),
    .tx      (tx_b),
    .tx_busy (busy_b),
    .tx_done (done_b)
  );

  always #5 clk = ~clk;

  // baud enable: high one clk in every div; div of 1 holds it high
  initial begin
    bclk_tx = 1'b0;
    forever begin
      @(negedge clk);
      phase = (phase + 1 >= div) ? 0 : phase + 1;
      bclk_tx = (phase == 0);
    end
  end

  // line monitor: one sample per tick, no change between ticks
  initial begin
    logic t, cur, d, b;
    forever begin
      @(posedge clk);
      t = bclk_tx;
      #1;
      cur = mon_sel ? tx_b : tx_a;
      d   = mon_sel ? done_b : done_a;
      b   = mon_sel ? busy_b : busy_a;
      if (t) obs.push_back(cur);
      else if (cur !== last_tx) hold_err++;
      if (d === 1'b1) begin
        done_cnt++;
        done_idx.push_back(obs.size() - 1);
        done_busy.push_back(b);
      end
      last_tx = cur;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic rdy();
    return mon_sel ? if_b.tx_ready : if_a.tx_ready;
  endfunction

  function automatic logic at(input int i);
    if (i >= 0 && i < obs.size()) return obs[i];
    return 1'bx;
  endfunction

  function automatic int first_zero();
    foreach (obs[i]) if (obs[i] === 1'b0) return i;
    return -1;
  endfunction

  task automatic drive(input logic st, input logic [7:0] w);
    if_a.tx_start = mon_sel ? 1'b0 : st;
    if_a.d_in_tx  = w;
    if_b.tx_start = mon_sel ? st : 1'b0;
    if_b.d_in_tx  = w;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // expected line periods of one frame, built from the framing rules
  task automatic model_frame(input logic [7:0] w);
    bit pe;
    int sb;
    int len;
    logic [11:0] f;
    pe  = !mon_sel;
    sb  = mon_sel ? 2 : 1;
    f   = '1;
    f[0] = 1'b0;
    f[8:1] = w;
    if (pe) f[9] = ^w;
    len = 10 + int'(pe) + sb - 1;
    for (int i = 0; i < len; i++) expq.push_back(f[i]);
    exp_done.push_back(expq.size());
  endtask

  task automatic send(input logic [7:0] w, input bit model);
    int n;
    n = 0;
    while (rdy() !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("send_wait", 32'(n < 400), 1);
    drive(1'b1, w);
    step();
    drive(1'b0, 8'h00);
    chk("ready_drop", rdy(), 0);
    if (model) model_frame(w);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 3000) begin
      step();
      k++;
    end
    repeat (2 * div + 2) step();
  endtask

  task automatic begin_test(input bit sel, input int d);
    mon_sel = sel;
    div = d;
    repeat (12) step();
    obs.delete();
    expq.delete();
    exp_done.delete();
    done_idx.delete();
    done_busy.delete();
    done_cnt = 0;
    hold_err = 0;
  endtask

  task automatic check_stream(input string tag, output int s);
    int nd;
    s = first_zero();
    chk({tag, "_start"}, 32'(s >= 0), 1);
    for (int k = 0; k < expq.size(); k++)
      chk($sformatf("%s_bit%0d", tag, k), at(s + k), expq[k]);
    chk({tag, "_idle"}, at(s + expq.size()), 1);
    nd = exp_done.size();
    chk({tag, "_done_n"}, done_cnt, nd);
    for (int k = 0; k < nd; k++) begin
      chk($sformatf("%s_done_pos%0d", tag, k),
          (k < done_idx.size()) ? done_idx[k] - s : -1,
          exp_done[k]);
      chk($sformatf("%s_busy_at_done%0d", tag, k),
          (k < done_busy.size()) ? done_busy[k] : 1'bx,
          (k == nd - 1) ? 0 : 1);
    end
    chk({tag, "_hold"}, hold_err, 0);
  endtask

  initial begin
    int s, k, n0, n;
    drive(1'b0, 8'h00);
    #1 reset = 1'b1;
    #1;
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_ready_a", if_a.tx_ready, 1);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_ready_b", if_b.tx_ready, 1);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("post_rst_tx", tx_a, 1);

    begin_test(1'b0, 4);
    send(8'hA5, 1'b1);
    wait_done(1);
    check_stream("a5", s);

    begin_test(1'b0, 4);
    send(8'h01, 1'b1);
    wait_done(1);
    check_stream("x01", s);

    begin_test(1'b0, 4);
    send(8'h3C, 1'b1);
    k = 0;
    while (rdy() !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("rdy_rise", 32'(k < 200), 1);
    chk("rdy_at_start", at(obs.size() - 1), 0);
    send(8'hC3, 1'b1);
    chk("full_ready", rdy(), 0);
    drive(1'b1, 8'hFF);
    repeat (3) step();
    drive(1'b0, 8'h00);
    chk("full_ready2", rdy(), 0);
    wait_done(2);
    check_stream("b2b", s);

    begin_test(1'b0, 4);
    send(8'h5A, 1'b0);
    send(8'h77, 1'b0);
    k = 0;
    s = first_zero();
    while (!(s >= 0 && obs.size() >= s + 5) && k < 400) begin
      step();
      k++;
      s = first_zero();
    end
    chk("bit3_reach", 32'(k < 400), 1);
    chk("bit3_val", at(s + 4), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ready", if_a.tx_ready, 1);
    chk("mid_rst_done", done_a, 0);
    repeat (3) step();
    chk("mid_rst_no_done", done_cnt, 0);
    reset = 1'b0;
    begin_test(1'b0, 4);
    send(8'h0F, 1'b1);
    wait_done(1);
    check_stream("after_rst", s);

    begin_test(1'b0, 4);
    k = 0;
    while (bclk_tx !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    n0 = obs.size();
    drive(1'b1, 8'h96);
    step();
    drive(1'b0, 8'h00);
    chk("tick_acc_line", at(n0), 1);
    model_frame(8'h96);
    wait_done(1);
    check_stream("tick_acc", s);
    chk("tick_acc_start", s, n0 + 1);

    for (int r = 0; r < 6; r++) begin
      begin_test(1'(r % 2), int'($urandom_range(1, 5)));
      n = int'($urandom_range(2, 4));
      for (int i = 0; i < n; i++) send(8'($urandom), 1'b1);
      wait_done(n);
      check_stream($sformatf("rand%0d", r), s);
    end

    begin_test(1'b1, 4);
    send(8'h80, 1'b1);
    wait_done(1);
    check_stream("b80", s);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
